// File: rtl/tiled_mult_seq_ctrl.sv
// Sequential WA x WB unsigned multiplier: one shared 3x2 cell evaluates one tile
// per cycle, and the shifted tile products are summed into a PW-bit accumulator.

module exact_3x2 (
  input  logic [2:0] x,
  input  logic [1:0] y,
  output logic [4:0] z
);

  assign z = ({2'b00, x} & {5{y[0]}}) + ({1'b0, x, 1'b0} & {5{y[1]}});

endmodule

module tiled_mult_seq_ctrl #(
  parameter int WA = 6,
  parameter int WB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WA-1:0]      a,
  input  logic [WB-1:0]      b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WA+WB-1:0]   p,
  output logic               busy
);

  localparam int NA = WA / 3;
  localparam int NB = WB / 2;
  localparam int NT = NA * NB;
  localparam int PW = WA + WB;
  localparam int KW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k;
  logic [WA-1:0]   a_reg;
  logic [WB-1:0]   b_reg;
  logic [PW-1:0]   acc;
  logic [2:0]      a_sl;
  logic [1:0]      b_sl;
  logic [4:0]      tile;
  logic [PW-1:0]   tile_sh;
  int              sh;

  // Tile k maps to multiplicand digit k/NB and multiplier digit k%NB.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    sh   = 0;
    for (int t = 0; t < NA; t++) begin
      for (int u = 0; u < NB; u++) begin
        if (k == KW'(t * NB + u)) begin
          a_sl = a_reg[3*t +: 3];
          b_sl = b_reg[2*u +: 2];
          sh   = 3 * t + 2 * u;
        end
      end
    end
  end

  exact_3x2 u_cell (
    .x (a_sl),
    .y (b_sl),
    .z (tile)
  );

  assign tile_sh = PW'(tile) << sh;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operands are latched only on acceptance, so a/b are free to change during RUN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          acc <= acc + tile_sh;
          if (k != K_LAST) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_tiled_mult_seq_ctrl.sv
// Bench for tiled_mult_seq_ctrl: three instances (6x4, 3x2, 9x6) checked against
// a plain a*b product and a handshake timing model of latency NT+1, interval NT+2.

module tb_tiled_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        out_ready = 1'b1;
  logic [8:0]  a_in = '0;
  logic [5:0]  b_in = '0;
  logic        in_valid_v [3];
  logic        in_ready_v [3];
  logic        out_valid_v [3];
  logic        busy_v [3];
  logic [9:0]  p0;
  logic [4:0]  p1;
  logic [14:0] p2;
  logic [14:0] p_v [3];

  int nt_v [3] = '{4, 1, 9};
  int n_asserts = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign p_v[0] = {5'b0, p0};
  assign p_v[1] = {10'b0, p1};
  assign p_v[2] = p2;

  tiled_mult_seq_ctrl #(.WA(6), .WB(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_in[5:0]), .b(b_in[3:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .p(p0), .busy(busy_v[0])
  );

  tiled_mult_seq_ctrl #(.WA(3), .WB(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_in[2:0]), .b(b_in[1:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .p(p1), .busy(busy_v[1])
  );

  tiled_mult_seq_ctrl #(.WA(9), .WB(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_in), .b(b_in), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .p(p2), .busy(busy_v[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_asserts++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after the handshake.
  task automatic xact(input int d, input int av, input int bv, input int stall,
                      input bit keep, input bit chk_iv, input int ja, input int jb);
    int n;
    int nt;
    int w;
    longint expv;
    if (n_fail > 50) return;
    nt   = nt_v[d];
    expv = longint'(av) * longint'(bv);
    a_in = 9'(av);
    b_in = 6'(bv);
    in_valid_v[d] = 1'b1;
    out_ready = (stall == 0);
    w = 0;
    while (!in_ready_v[d] && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", in_ready_v[d], 1);
    if (chk_iv) chk("issue_interval", cyc - last_acc, nt + 2);
    last_acc = cyc;
    @(negedge clk);
    in_valid_v[d] = keep;
    a_in = (ja < 0) ? 9'($urandom) : 9'(ja);
    b_in = (jb < 0) ? 6'($urandom) : 6'(jb);
    chk("in_ready_run", in_ready_v[d], 0);
    chk("busy_run", busy_v[d], 1);
    n = 1;
    while (!out_valid_v[d] && n < nt + 6) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, nt + 1);
    chk("product", p_v[d], expv);
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid_v[d], 1);
      chk("stall_p", p_v[d], expv);
      chk("stall_in_ready", in_ready_v[d], 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", out_valid_v[d], 0);
    chk("post_in_ready", in_ready_v[d], 1);
    chk("post_busy", busy_v[d], 0);
    if (!keep) in_valid_v[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) in_valid_v[d] = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", in_ready_v[d], 1);
      chk("rst_out_valid", out_valid_v[d], 0);
      chk("rst_busy", busy_v[d], 0);
      chk("rst_p", p_v[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 63, 15, 0, 1'b0, 1'b0, -1, -1);

    xact(0, 5, 3, 0, 1'b1, 1'b0, -1, -1);
    xact(0, 0, 15, 0, 1'b1, 1'b1, -1, -1);
    xact(0, 42, 0, 0, 1'b1, 1'b1, -1, -1);
    xact(0, 1, 1, 0, 1'b0, 1'b1, -1, -1);

    xact(0, 37, 9, 7, 1'b0, 1'b0, -1, -1);

    xact(0, 21, 6, 0, 1'b0, 1'b0, 63, 15);

    // Asynchronous reset in the second RUN cycle.
    a_in = 9'd50;
    b_in = 6'd11;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk("mid_busy_before", busy_v[0], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid_v[0], 0);
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_p", p_v[0], 0);
    chk("mid_rst_in_ready", in_ready_v[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid_v[0], 0);
    end

    for (int av = 0; av < 64; av++)
      for (int bv = 0; bv < 16; bv++)
        xact(0, av, bv, 0, 1'b0, 1'b0, -1, -1);

    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 4; bv++)
        xact(1, av, bv, (bv == 3) ? 2 : 0, 1'b0, 1'b0, -1, -1);

    for (int r = 0; r < 2000; r++)
      xact(2, int'($urandom_range(511, 0)), int'($urandom_range(63, 0)),
           0, 1'b0, 1'b0, -1, -1);
    xact(2, 511, 63, 0, 1'b0, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tiled_mult_seq_ctrl.md
Name: tiled_mult_seq_ctrl

Overview:
Sequential controller that computes a WA x WB unsigned product with a single shared exact_3x2 cell. It schedules one 3x2 tile product per cycle, shifts it into place and accumulates. It sits between a valid/ready operand source and a valid/ready result sink. It is the area-minimal alternative to a full-width array multiplier.

Parameters:
WA, 6, multiplicand width; must be a multiple of 3 and at least 3.
WB, 4, multiplier width; must be a multiple of 2 and at least 2.
Derived (localparam, not overridable): NA = WA/3; NB = WB/2; NT = NA*NB tiles; PW = WA+WB.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand pair a/b valid.
in_ready  out  1  controller can accept operands.
a  in  WA  unsigned multiplicand.
b  in  WB  unsigned multiplier.
out_valid  out  1  product p valid.
out_ready  in  1  sink accepts p.
p  out  PW  unsigned product a*b.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, tile counter=0, accumulator=0, operand registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a and b into registers, clear the accumulator, set k=0, go to RUN.
  - RUN: in_ready=0. Each cycle, tile k uses i=k/NB and j=k%NB. The slice a_reg[3i+2:3i] and the slice b_reg[2j+1:2j] drive the exact_3x2 instance. Its 5-bit result is zero-extended to PW, shifted left by 3i+2j, and added to the accumulator. k increments each cycle. After the tile k=NT-1 is accumulated, go to DONE.
  - DONE: out_valid=1, p=accumulator. p and out_valid stay stable until out_valid&out_ready. On that handshake, go to IDLE.
- Output register: p is driven from the accumulator register. p is don't-care outside DONE, but the implementation must hold the last value, not glitch it.
- Latency: operand accepted at edge T. RUN occupies cycles T+1..T+NT. out_valid rises at cycle T+NT+1. For the defaults (NT=4), the product is visible 5 cycles after acceptance. Minimum issue interval is NT+2 cycles.
- No overlap:
  - in_ready=0 in RUN and DONE. in_valid is ignored there and a/b may change freely.
  - The DONE->IDLE handshake and a new operand acceptance never occur in the same cycle. A new operand is accepted at the earliest one cycle after the result handshake.
- Arithmetic:
  - The accumulator is PW bits and never overflows. The maximum sum equals (2^WA-1)(2^WB-1) < 2^PW.
  - All arithmetic is unsigned.
- Backpressure: out_ready low in DONE holds the state indefinitely. No tile is recomputed.
- Counter: k is wide enough for NT-1 (clog2(NT), minimum 1 bit). k resets to 0 on entry to RUN and never wraps past NT-1.
- Reset mid-operation: an asynchronous assert in RUN or DONE discards the operands and partial sum. Outputs go to their reset values immediately. No result is emitted after reset deasserts.
- Degenerate configuration: when WA=3 and WB=2, NT=1 and RUN lasts exactly 1 cycle.
- Inputs with X/Z values on a/b outside the accept cycle must not affect p.

Test Plan:
- Reset, then a=63, b=15 with in_valid=1 and out_ready=1 -> in_ready drops the cycle after acceptance. out_valid rises exactly 5 cycles after acceptance with p=945. in_ready returns to 1 one cycle after the handshake.
- Back-to-back pairs (5,3), (0,15), (42,0), (1,1) with in_valid held high -> p=15, 0, 0, 1 in order. The issue interval is exactly 6 cycles.
- Backpressure: a=37, b=9 with out_ready held low for 7 cycles -> out_valid=1 and p=333 stay stable all 7 cycles. in_ready=0 throughout. The result handshakes on the first out_ready=1 cycle.
- Reset mid-operation: accept a=50, b=11, then pull rst_n low asynchronously during the second RUN cycle -> out_valid, busy and p go to 0 immediately. After release, no out_valid appears until a new operand is accepted.
- Operand change after accept: accept a=21, b=6, then drive a=63, b=15 during RUN -> p=126.
- Exhaustive sweep plus parameter check: all 64x16 pairs at defaults match a*b. Rerun with WA=3, WB=2 (latency 2, all 8x4 pairs) and WA=9, WB=6 (NT=9, random 2000 pairs) against a reference model.
